// File: rtl/m_spi_slave_port.sv
// Mode-0 SPI responder: oversamples SCLK/SS_N/MOSI in the I_CLK domain, deserialises MOSI
// MSB-first and serialises a buffered host word onto MISO, with valid/ready handshakes and sticky flags.
module m_spi_slave_port #(
   parameter int unsigned            DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0]  DEFAULT_TX = DATA_WIDTH'(8'hFF)
) (
   input  logic                  I_CLK,
   input  logic                  I_RESETN,
   input  logic                  SCLK,
   input  logic                  SS_N,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  MISO_OE,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  busy,
   output logic                  rx_overrun,
   output logic                  tx_underrun,
   output logic                  frame_err,
   input  logic                  clr_status
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] tx_buf;
   logic [DATA_WIDTH-2:0] rx_shift;

   logic sclk_s1, sclk_s2, sclk_d;
   logic ss_s1, ss_s2, ss_d;
   logic mosi_s1, mosi_s2;
   logic sclk_rise, sclk_fall, ss_fall, ss_rise;
   logic word_done, load;

   // Two-flop synchronisers plus one edge-detect stage; SS_N idles high
   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_d  <= 1'b0;
         ss_s1   <= 1'b1;
         ss_s2   <= 1'b1;
         ss_d    <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sclk_s1 <= SCLK;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
         ss_s1   <= SS_N;
         ss_s2   <= ss_s1;
         ss_d    <= ss_s2;
         mosi_s1 <= MOSI;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_d;
   assign sclk_fall = ~sclk_s2 & sclk_d;
   assign ss_fall   = ~ss_s2 & ss_d;
   assign ss_rise   = ss_s2 & ~ss_d;
   assign word_done = (bit_cnt == CNT_FULL);

   // Shifter reload: at frame start, or on the first fall after a completed word
   assign load = (state == IDLE) ? ss_fall : (~ss_rise & sclk_fall & word_done);

   assign busy    = (state == ACTIVE);
   assign MISO_OE = (state == ACTIVE);
   assign MISO    = (state == ACTIVE) & tx_shift[DATA_WIDTH-1];

   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         tx_shift    <= '0;
         tx_buf      <= '0;
         tx_ready    <= 1'b1;
         rx_shift    <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         // Clear first so that a same-cycle set further down wins
         if (clr_status) begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
         end

         if (rx_valid && rx_ready) rx_valid <= 1'b0;

         if (tx_valid && tx_ready) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
         end

         if (load) begin
            tx_shift <= tx_ready ? DEFAULT_TX : tx_buf;
            if (!tx_ready) tx_ready <= 1'b1;
            if (tx_ready && state == ACTIVE) tx_underrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state   <= ACTIVE;
                  bit_cnt <= '0;
               end
            end
            ACTIVE: begin
               if (ss_rise) begin
                  state <= IDLE;
                  if (bit_cnt != '0 && !word_done) frame_err <= 1'b1;
               end else if (sclk_rise && !word_done) begin
                  rx_shift <= (DATA_WIDTH-1)'({rx_shift, mosi_s2});
                  bit_cnt  <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_FULL - CNT_W'(1)) begin
                     rx_data  <= {rx_shift, mosi_s2};
                     rx_valid <= 1'b1;
                     if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
                  end
               end else if (sclk_fall) begin
                  if (word_done) bit_cnt <= '0;
                  else           tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m_spi_slave_port.sv
// Self-checking bench for m_spi_slave_port: bit-banged SPI master frames checked against
// a word-level model of the TX buffer, RX handshake and sticky flags.
module tb_m_spi_slave_port;

   logic       I_CLK = 1'b0;
   logic       I_RESETN;
   logic       SCLK, SS_N, MOSI;
   logic       MISO, MISO_OE;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic       busy, rx_overrun, tx_underrun, frame_err, clr_status;

   m_spi_slave_port #(.DATA_WIDTH(8), .DEFAULT_TX(8'hFF)) dut (
      .I_CLK(I_CLK), .I_RESETN(I_RESETN), .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI),
      .MISO(MISO), .MISO_OE(MISO_OE), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
      .frame_err(frame_err), .clr_status(clr_status)
   );

   always #5 I_CLK = ~I_CLK;

   int n_checks = 0;
   int n_pass   = 0;

   // Frame stimulus and results
   logic [7:0] mosi_q   [4];
   logic [7:0] miso_got [4];
   logic [7:0] exp_miso [4];
   int         wr_word;
   logic [7:0] wr_data;

   // Word-level reference model
   logic [7:0] m_buf;
   logic       m_full, m_rxv, m_ovr, m_und, m_ferr;
   logic [7:0] m_rxd;
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];

   always @(posedge I_CLK)
      if (I_RESETN === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);

   task automatic wait_clk(input int n);
      repeat (n) @(posedge I_CLK);
      #1;
   endtask

   function automatic void model_reset();
      m_buf = 8'h00; m_full = 1'b0; m_rxv = 1'b0; m_ovr = 1'b0;
      m_und = 1'b0; m_ferr = 1'b0; m_rxd = 8'h00;
   endfunction

   // One SS_N-low frame: nw whole words then an optional partial word of 'partial' bits
   function automatic void model_frame(input int nw, input int partial, input logic rr);
      int nloads = nw + ((partial > 0) ? 1 : 0);
      if (rr && m_rxv) begin exp_q.push_back(m_rxd); m_rxv = 1'b0; end
      for (int i = 0; i < nloads; i++) begin
         exp_miso[i] = m_full ? m_buf : 8'hFF;
         if (!m_full && i > 0) m_und = 1'b1;
         m_full = 1'b0;
         if (wr_word == i) begin m_buf = wr_data; m_full = 1'b1; end
         if (i < nw) begin
            if (m_rxv && !rr) m_ovr = 1'b1;
            m_rxd = mosi_q[i];
            m_rxv = 1'b1;
            if (rr) begin exp_q.push_back(mosi_q[i]); m_rxv = 1'b0; end
         end
      end
      if (partial > 0) m_ferr = 1'b1;
   endfunction

   task automatic tx_write(input logic [7:0] d);
      n_checks++;
      if (tx_ready !== ~m_full) $display("FAIL tx_ready_pre_write: got %b want %b", tx_ready, ~m_full);
      else n_pass++;
      tx_data = d; tx_valid = 1'b1;
      wait_clk(1);
      tx_valid = 1'b0;
      if (!m_full) begin m_buf = d; m_full = 1'b1; end
   endtask

   task automatic run_frame(input int nw, input int partial, input logic rr, input logic do_clr);
      int   half;
      int   nloads;
      logic oe_seen;
      logic q_ok;
      nloads = nw + ((partial > 0) ? 1 : 0);
      half   = int'($urandom_range(11, 8));
      rx_ready = rr;
      wait_clk(3);
      SS_N = 1'b0;
      wait_clk(half);
      oe_seen = MISO_OE;
      for (int w = 0; w < nloads; w++) begin
         int nb = (w < nw) ? 8 : partial;
         for (int b = 0; b < nb; b++) begin
            MOSI = mosi_q[w][7-b];
            wait_clk(half);
            miso_got[w][7-b] = MISO;
            SCLK = 1'b1;
            wait_clk(half);
            if (w == wr_word && b == 3) begin
               n_checks++;
               if (tx_ready !== 1'b1) $display("FAIL tx_ready_mid_word: got %b want 1", tx_ready);
               else n_pass++;
               tx_data = wr_data; tx_valid = 1'b1;
               wait_clk(1);
               tx_valid = 1'b0;
            end
            SCLK = 1'b0;
            if (w == nloads - 1 && b == nb - 1) SS_N = 1'b1;
         end
      end
      wait_clk(6);
      model_frame(nw, partial, rr);

      n_checks++;
      if (oe_seen !== 1'b1) $display("FAIL miso_oe_in_frame: got %b want 1", oe_seen);
      else n_pass++;
      for (int i = 0; i < nw; i++) begin
         n_checks++;
         if (miso_got[i] !== exp_miso[i])
            $display("FAIL miso_word%0d: got %h want %h", i, miso_got[i], exp_miso[i]);
         else n_pass++;
      end
      n_checks++;
      if ({busy, MISO_OE, MISO, tx_ready, rx_valid, rx_overrun, tx_underrun, frame_err} !==
          {3'b000, ~m_full, m_rxv, m_ovr, m_und, m_ferr})
         $display("FAIL status {busy,oe,miso,txr,rxv,ovr,und,ferr}: got %b want %b",
                  {busy, MISO_OE, MISO, tx_ready, rx_valid, rx_overrun, tx_underrun, frame_err},
                  {3'b000, ~m_full, m_rxv, m_ovr, m_und, m_ferr});
      else n_pass++;
      n_checks++;
      if (rx_data !== m_rxd) $display("FAIL rx_data: got %h want %h", rx_data, m_rxd);
      else n_pass++;
      q_ok = (got_q.size() == exp_q.size());
      if (q_ok) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) q_ok = 1'b0;
      n_checks++;
      if (!q_ok) $display("FAIL rx_consumed: got %0d words (last %h) want %0d words (last %h)",
                          got_q.size(), (got_q.size() > 0) ? got_q[$] : 8'hxx,
                          exp_q.size(), (exp_q.size() > 0) ? exp_q[$] : 8'hxx);
      else n_pass++;

      if (do_clr) begin
         clr_status = 1'b1;
         wait_clk(1);
         clr_status = 1'b0;
         m_ovr = 1'b0; m_und = 1'b0; m_ferr = 1'b0;
         n_checks++;
         if ({rx_overrun, tx_underrun, frame_err} !== 3'b000)
            $display("FAIL clr_status: got %b want 000", {rx_overrun, tx_underrun, frame_err});
         else n_pass++;
      end
   endtask

   task automatic test_reset;
      I_RESETN = 1'b0; SCLK = 1'b0; SS_N = 1'b1; MOSI = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; clr_status = 1'b0;
      wait_clk(4);
      n_checks++;
      if ({MISO, MISO_OE, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun, frame_err} !==
          {3'b001, 8'h00, 5'b00000})
         $display("FAIL reset_values: got %b want %b",
                  {MISO, MISO_OE, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun, frame_err},
                  {3'b001, 8'h00, 5'b00000});
      else n_pass++;
      I_RESETN = 1'b1;
      model_reset();
      wait_clk(3);
   endtask

   task automatic test_basic;
      tx_write(8'hA5);
      mosi_q[0] = 8'h3C; wr_word = -1;
      run_frame(1, 0, 1'b0, 1'b0);
      n_checks++;
      if (MISO_OE !== 1'b0) $display("FAIL miso_oe_after_frame: got %b want 0", MISO_OE);
      else n_pass++;
   endtask

   task automatic test_default_tx;
      mosi_q[0] = 8'h81; wr_word = -1;
      run_frame(1, 0, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back;
      tx_write(8'h11);
      mosi_q[0] = 8'hC3; mosi_q[1] = 8'h5A; wr_word = 0; wr_data = 8'h22;
      run_frame(2, 0, 1'b1, 1'b0);
   endtask

   task automatic test_overrun_underrun;
      mosi_q[0] = 8'hC3; mosi_q[1] = 8'h5A; wr_word = -1;
      run_frame(2, 0, 1'b0, 1'b1);
   endtask

   task automatic test_frame_err;
      mosi_q[0] = 8'h6B; wr_word = -1;
      run_frame(0, 5, 1'b0, 1'b0);
      mosi_q[0] = 8'h96;
      run_frame(1, 0, 1'b1, 1'b1);
   endtask

   task automatic test_reset_midframe;
      tx_write(8'h3E);
      rx_ready = 1'b0;
      SS_N = 1'b0;
      wait_clk(10);
      for (int b = 0; b < 3; b++) begin
         MOSI = 1'($urandom());
         wait_clk(9); SCLK = 1'b1;
         wait_clk(9); SCLK = 1'b0;
      end
      wait_clk(4);
      I_RESETN = 1'b0;
      #2;
      n_checks++;
      if ({MISO, MISO_OE, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun, frame_err} !==
          {3'b001, 8'h00, 5'b00000})
         $display("FAIL midframe_reset_values: got %b want %b",
                  {MISO, MISO_OE, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun, frame_err},
                  {3'b001, 8'h00, 5'b00000});
      else n_pass++;
      SS_N = 1'b1; SCLK = 1'b0;
      wait_clk(2);
      I_RESETN = 1'b1;
      model_reset();
      wait_clk(3);
      tx_write(8'hD2);
      mosi_q[0] = 8'h47; wr_word = -1;
      run_frame(1, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      for (int f = 0; f < 24; f++) begin
         int nw      = int'($urandom_range(3, 1));
         int partial = (($urandom() % 6) == 0) ? int'($urandom_range(7, 1)) : 0;
         if ($urandom() % 2 == 0) tx_write(8'($urandom()));
         for (int i = 0; i < 4; i++) mosi_q[i] = 8'($urandom());
         wr_word = int'($urandom_range(unsigned'(nw), 0)) - 1;
         wr_data = 8'($urandom());
         run_frame(nw, partial, 1'($urandom()), (($urandom() % 3) == 0));
      end
   endtask

   initial begin
      wr_word = -1; wr_data = 8'h00;
      model_reset();
      test_reset();
      test_basic();
      test_default_tx();
      test_back_to_back();
      test_overrun_underrun();
      test_frame_err();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
